axi_data_cache: RTL and testbench

//  Single-port, direct-mapped, write-back, write-allocate word cache between a core's memory

---
 rtl/axi_data_cache.sv | 219 +++++++++++++++++++++
 tb/tb_axi_data_cache.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_data_cache.sv
//============================================================================
// Module  : axi_data_cache
// Brief   : Direct-mapped write-back / write-allocate word cache with AXI4
//           INCR-burst line fill and eviction. Define CACHE_PERF_EN to add
//           HIT_COUNT / MISS_COUNT lookup counters.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module axi_data_cache #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RECEIVE_ADDR_VALID,
  input  logic [31:0] RECEIVE_ADDR,
  input  logic        RECEIVE_DATA_VALID,
  input  logic [31:0] RECEIVE_DATA,
  output logic        RECEIVE_READY,
  output logic        SEND_VALID,
  output logic [31:0] SEND_DATA,
  input  logic        SEND_READY,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic        WVALID,
  output logic        WLAST,
`ifdef CACHE_PERF_EN
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT,
`endif
  input  logic        WREADY
);

  localparam int c_LINE_WORDS = 2 ** OFFSET_WIDTH;
  localparam int c_LINES      = 2 ** INDEX_WIDTH;
  localparam int c_TAG_LSB    = 2 + OFFSET_WIDTH + INDEX_WIDTH;
  localparam int c_TAG_W      = 32 - c_TAG_LSB;
  localparam logic [OFFSET_WIDTH-1:0] c_LAST_BEAT = '1;

  // TAGRD gives the tag/valid/dirty arrays a registered read before compare
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TAGRD   = 3'd1,
    S_LOOKUP  = 3'd2,
    S_RESPOND = 3'd3,
    S_WB_AW   = 3'd4,
    S_WB_W    = 3'd5,
    S_FILL_AR = 3'd6,
    S_FILL_R  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]             r_data_mem [c_LINES*c_LINE_WORDS];
  logic [c_TAG_W-1:0]      r_tag_mem  [c_LINES];
  logic [c_LINES-1:0]      r_valid;
  logic [c_LINES-1:0]      r_dirty;

  logic [c_TAG_W-1:0]      r_req_tag;
  logic [INDEX_WIDTH-1:0]  r_req_index;
  logic [OFFSET_WIDTH-1:0] r_req_off;
  logic                    r_req_write;
  logic [31:0]             r_req_wdata;

  logic                    r_rd_valid;
  logic                    r_rd_dirty;
  logic [c_TAG_W-1:0]      r_rd_tag;
  logic [OFFSET_WIDTH-1:0] r_beat;
  logic [31:0]             r_send_data;
  logic                    r_out_en;

  logic w_accept;
  logic w_hit;
  logic w_wbeat;
  logic w_rbeat;
  logic w_unused;
  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] w_word_addr;
  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] w_beat_addr;

  assign w_unused    = ^RECEIVE_ADDR[1:0];
  assign w_accept    = RECEIVE_ADDR_VALID && RECEIVE_READY;
  assign w_hit       = r_rd_valid && (r_rd_tag == r_req_tag);
  assign w_wbeat     = (r_state == S_WB_W) && WREADY;
  assign w_rbeat     = (r_state == S_FILL_R) && RVALID;
  assign w_word_addr = {r_req_index, r_req_off};
  assign w_beat_addr = {r_req_index, r_beat};

  // r_out_en keeps RECEIVE_READY low until the first edge after reset release
  assign RECEIVE_READY = (r_state == S_IDLE) && r_out_en;
  assign SEND_VALID    = (r_state == S_RESPOND);
  assign SEND_DATA     = r_send_data;
  assign ARVALID       = (r_state == S_FILL_AR);
  assign ARADDR        = ARVALID ? {r_req_tag, r_req_index, {(OFFSET_WIDTH+2){1'b0}}} : '0;
  assign RREADY        = (r_state == S_FILL_R);
  assign AWVALID       = (r_state == S_WB_AW);
  assign AWADDR        = AWVALID ? {r_rd_tag, r_req_index, {(OFFSET_WIDTH+2){1'b0}}} : '0;
  assign WVALID        = (r_state == S_WB_W);
  assign WLAST         = WVALID && (r_beat == c_LAST_BEAT);
  assign WDATA         = WVALID ? r_data_mem[w_beat_addr] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_TAGRD;
      S_TAGRD:   w_next_state = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)                         w_next_state = S_RESPOND;
        else if (r_rd_valid && r_rd_dirty) w_next_state = S_WB_AW;
        else                               w_next_state = S_FILL_AR;
      end
      S_RESPOND: if (SEND_READY) w_next_state = S_IDLE;
      S_WB_AW:   if (AWREADY) w_next_state = S_WB_W;
      S_WB_W:    if (w_wbeat && (r_beat == c_LAST_BEAT)) w_next_state = S_FILL_AR;
      S_FILL_AR: if (ARREADY) w_next_state = S_FILL_R;
      S_FILL_R:  if (w_rbeat && (r_beat == c_LAST_BEAT)) w_next_state = S_TAGRD;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_en    <= 1'b0;
      r_req_tag   <= '0;
      r_req_index <= '0;
      r_req_off   <= '0;
      r_req_write <= 1'b0;
      r_req_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_dirty  <= 1'b0;
      r_rd_tag    <= '0;
      r_beat      <= '0;
      r_send_data <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
    end else begin
      r_out_en <= 1'b1;
      if (w_accept) begin
        r_req_tag   <= RECEIVE_ADDR[31:c_TAG_LSB];
        r_req_index <= RECEIVE_ADDR[c_TAG_LSB-1 -: INDEX_WIDTH];
        r_req_off   <= RECEIVE_ADDR[2 +: OFFSET_WIDTH];
        r_req_write <= RECEIVE_DATA_VALID;
        r_req_wdata <= RECEIVE_DATA;
      end
      if (r_state == S_TAGRD) begin
        r_rd_valid <= r_valid[r_req_index];
        r_rd_dirty <= r_dirty[r_req_index];
        r_rd_tag   <= r_tag_mem[r_req_index];
      end
      if ((r_state == S_LOOKUP) && w_hit) begin
        r_send_data <= r_req_write ? r_req_wdata : r_data_mem[w_word_addr];
        if (r_req_write) r_dirty[r_req_index] <= 1'b1;
      end
      // One counter serves both bursts; it wraps back to zero after the last beat
      if (w_wbeat || w_rbeat) r_beat <= r_beat + OFFSET_WIDTH'(1);
      if (w_rbeat && (r_beat == c_LAST_BEAT)) begin
        r_valid[r_req_index] <= 1'b1;
        r_dirty[r_req_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if ((r_state == S_LOOKUP) && w_hit && r_req_write) begin
      r_data_mem[w_word_addr] <= r_req_wdata;
    end
    if (w_rbeat) begin
      r_data_mem[w_beat_addr] <= RDATA;
      if (r_beat == c_LAST_BEAT) r_tag_mem[r_req_index] <= r_req_tag;
    end
  end

`ifdef CACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_post_fill;

  // The lookup that replays a request after its own fill is not a new access
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_post_fill  <= 1'b0;
    end else begin
      if (w_rbeat && (r_beat == c_LAST_BEAT)) r_post_fill <= 1'b1;
      if (r_state == S_LOOKUP) begin
        r_post_fill <= 1'b0;
        if (!r_post_fill) begin
          if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
          else       r_miss_count <= r_miss_count + 32'd1;
        end
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_data_cache.sv
//============================================================================
// Module  : tb_axi_data_cache
// Brief   : Self-checking bench for axi_data_cache with an AXI DRAM slave
//           model and a flat-memory reference for the core's view.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_axi_data_cache;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RECEIVE_ADDR_VALID = 1'b0;
  logic [31:0] RECEIVE_ADDR = '0;
  logic        RECEIVE_DATA_VALID = 1'b0;
  logic [31:0] RECEIVE_DATA = '0;
  logic        RECEIVE_READY;
  logic        SEND_VALID;
  logic [31:0] SEND_DATA;
  logic        SEND_READY = 1'b0;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WLAST;
  logic        WREADY;
`ifdef CACHE_PERF_EN
  logic [31:0] HIT_COUNT;
  logic [31:0] MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  axi_data_cache dut (
    .CLK(CLK), .RST(RST),
    .RECEIVE_ADDR_VALID(RECEIVE_ADDR_VALID), .RECEIVE_ADDR(RECEIVE_ADDR),
    .RECEIVE_DATA_VALID(RECEIVE_DATA_VALID), .RECEIVE_DATA(RECEIVE_DATA),
    .RECEIVE_READY(RECEIVE_READY),
    .SEND_VALID(SEND_VALID), .SEND_DATA(SEND_DATA), .SEND_READY(SEND_READY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST),
`ifdef CACHE_PERF_EN
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
    .WREADY(WREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // DRAM contents and the core-visible flat memory model
  logic [31:0] dram    [int unsigned];
  logic [31:0] exp_mem [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) + 32'h0000_1357;
  endfunction

  function automatic logic [31:0] dram_get(input logic [31:0] a);
    return dram.exists(a) ? dram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return exp_mem.exists(k) ? exp_mem[k] : dram_get(k);
  endfunction

  // AXI slave: decides at each falling edge what the next rising edge transfers
  bit          stall_en = 1'b0;
  bit          rd_active, wr_active, r_hold;
  int          rd_beat, wr_beat;
  int          ar_count = 0;
  int          aw_count = 0;
  logic [31:0] rd_base, wr_base, last_araddr, last_awaddr, w_beat1;

  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; AWREADY = 1'b0; WREADY = 1'b0;
    rd_active = 1'b0; wr_active = 1'b0; r_hold = 1'b0; rd_beat = 0; wr_beat = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        rd_active = 1'b0; wr_active = 1'b0; r_hold = 1'b0;
      end else begin
        if (rd_active) begin
          if (!r_hold) RVALID = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          RDATA = dram_get(rd_base + 32'(4 * rd_beat));
          if (RVALID && RREADY) begin
            r_hold = 1'b0;
            rd_beat++;
            if (rd_beat == 8) rd_active = 1'b0;
          end else begin
            r_hold = RVALID;
          end
        end else begin
          RVALID = 1'b0;
          r_hold = 1'b0;
        end
        if (wr_active) begin
          WREADY = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (WVALID && WREADY) begin
            check($sformatf("wlast beat%0d", wr_beat), WLAST, (wr_beat == 7));
            dram[wr_base + 32'(4 * wr_beat)] = WDATA;
            if (wr_beat == 1) w_beat1 = WDATA;
            wr_beat++;
            if (wr_beat == 8) wr_active = 1'b0;
          end
        end else begin
          WREADY = 1'b0;
        end
        if (!wr_active) begin
          AWREADY = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
          if (AWVALID && AWREADY) begin
            check("awaddr_align", AWADDR[4:0], 5'd0);
            aw_count++; last_awaddr = AWADDR; wr_base = AWADDR; wr_beat = 0; wr_active = 1'b1;
          end
        end else begin
          AWREADY = 1'b0;
        end
        if (!rd_active) begin
          ARREADY = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
          if (ARVALID && ARREADY) begin
            check("ar_after_last_w", wr_active, 1'b0);
            check("araddr_align", ARADDR[4:0], 5'd0);
            ar_count++; last_araddr = ARADDR; rd_base = ARADDR; rd_beat = 0; rd_active = 1'b1;
          end
        end else begin
          ARREADY = 1'b0;
        end
      end
    end
  end

  // One core request; lat = edges after the accept edge until SEND_VALID is seen
  task automatic core_op(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd, output int lat,
                         output bit stable_ok);
    int t;
    rd = '0; lat = -1; stable_ok = 1'b1;
    @(negedge CLK);
    t = 0;
    while (!RECEIVE_READY && t < 2000) begin @(negedge CLK); t++; end
    if (!RECEIVE_READY) begin fail_now("receive_ready_wait"); return; end
    RECEIVE_ADDR_VALID = 1'b1; RECEIVE_ADDR = a; RECEIVE_DATA_VALID = wr; RECEIVE_DATA = wd;
    @(negedge CLK);
    RECEIVE_ADDR_VALID = 1'b0; RECEIVE_DATA_VALID = 1'b0;
    t = 0;
    while (!SEND_VALID && t < 2000) begin @(negedge CLK); t++; end
    if (!SEND_VALID) begin fail_now("send_valid_wait"); return; end
    lat = t;
    rd  = SEND_DATA;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (!SEND_VALID || SEND_DATA !== rd || RECEIVE_READY) stable_ok = 1'b0;
    end
    SEND_READY = 1'b1;
    @(negedge CLK);
    SEND_READY = 1'b0;
    if (wr) exp_mem[{a[31:2], 2'b00}] = wd;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_ar;
    int          exp_aw;
    logic [31:0] exp_araddr;
    logic [31:0] exp_awaddr;
    int          exp_lat;
    bit          chk_beat1;
    logic [31:0] exp_beat1;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] rd, a, b, wd;
  int          lat, ar0, aw0, t;
  bit          ok;

  initial begin
    vecs[0] = '{32'h104,  1'b1, 32'h12345678, 32'h12345678,          1, 0, 32'h100,  32'h0,   -1, 1'b0, 32'h0};
    vecs[1] = '{32'h104,  1'b0, 32'h0,        32'h12345678,          0, 0, 32'h0,    32'h0,    2, 1'b0, 32'h0};
    vecs[2] = '{32'h4104, 1'b0, 32'h0,        init_word(32'h4104),   1, 1, 32'h4100, 32'h100, -1, 1'b1, 32'h12345678};
    vecs[3] = '{32'h104,  1'b0, 32'h0,        32'h12345678,          1, 0, 32'h100,  32'h0,   -1, 1'b0, 32'h0};
    vecs[4] = '{32'h108,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D,          0, 0, 32'h0,    32'h0,    2, 1'b0, 32'h0};
    vecs[5] = '{32'h11C,  1'b0, 32'h0,        init_word(32'h11C),    0, 0, 32'h0,    32'h0,    2, 1'b0, 32'h0};
    vecs[6] = '{32'h4100, 1'b0, 32'h0,        init_word(32'h4100),   1, 1, 32'h4100, 32'h100, -1, 1'b1, 32'h12345678};
    vecs[7] = '{32'h108,  1'b0, 32'h0,        32'hCAFEF00D,          1, 0, 32'h100,  32'h0,   -1, 1'b0, 32'h0};
    vecs[8] = '{32'h200,  1'b0, 32'h0,        init_word(32'h200),    1, 0, 32'h200,  32'h0,   -1, 1'b0, 32'h0};

    // Reset state
    #2 RST = 1'b1;
    #1 check("ready_in_reset", RECEIVE_READY, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_reset", RECEIVE_READY, 1'b1);
    check("valids_after_reset", {ARVALID, AWVALID, WVALID, SEND_VALID}, 4'b0000);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      ar0 = ar_count; aw0 = aw_count;
      core_op(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 0, rd, lat, ok);
      check($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d ar_bursts", i), ar_count - ar0, vecs[i].exp_ar);
      check($sformatf("vec%0d aw_bursts", i), aw_count - aw0, vecs[i].exp_aw);
      if (vecs[i].exp_ar != 0) check($sformatf("vec%0d araddr", i), last_araddr, vecs[i].exp_araddr);
      if (vecs[i].exp_aw != 0) check($sformatf("vec%0d awaddr", i), last_awaddr, vecs[i].exp_awaddr);
      if (vecs[i].chk_beat1)   check($sformatf("vec%0d wbeat1", i), w_beat1, vecs[i].exp_beat1);
      if (vecs[i].exp_lat >= 0) check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
    end

    // Consumer back-pressure for five cycles
    core_op(32'h104, 1'b0, 32'h0, 5, rd, lat, ok);
    check("hold_stable", ok, 1'b1);
    check("hold_data", rd, 32'h12345678);

    // Reset in the middle of a line fill
    stall_en = 1'b0;
    @(negedge CLK);
    t = 0;
    while (!RECEIVE_READY && t < 100) begin @(negedge CLK); t++; end
    RECEIVE_ADDR_VALID = 1'b1; RECEIVE_ADDR = 32'h2000; RECEIVE_DATA_VALID = 1'b0;
    @(negedge CLK);
    RECEIVE_ADDR_VALID = 1'b0;
    t = 0;
    while (!(RREADY && rd_beat >= 3) && t < 200) begin @(negedge CLK); t++; end
    check("reached_fill_r", RREADY, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_ctrl", {RECEIVE_READY, SEND_VALID, ARVALID, RREADY, AWVALID, WVALID, WLAST}, 7'b0);
    check("rst_mid_addr", {ARADDR, AWADDR}, 64'h0);
    check("rst_mid_data", {SEND_DATA, WDATA}, 64'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    exp_mem.delete();
    #1 check("ready_before_edge", RECEIVE_READY, 1'b0);
    @(posedge CLK); #1;
    check("ready_after_mid_reset", RECEIVE_READY, 1'b1);
    ar0 = ar_count;
    core_op(32'h2000, 1'b0, 32'h0, 0, rd, lat, ok);
    check("refetch_ar", ar_count - ar0, 1);
    check("refetch_data", rd, model_read(32'h2000));

    // Random write/read pairs under AXI stalls, with conflicting tags
    stall_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a  = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      b  = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      wd = $urandom;
      core_op(a, 1'b1, wd, 0, rd, lat, ok);
      check($sformatf("rnd%0d write_resp", i), rd, wd);
      core_op(b, 1'b0, 32'h0, 0, rd, lat, ok);
      check($sformatf("rnd%0d other_read", i), rd, model_read(b));
      core_op(a, 1'b0, 32'h0, 0, rd, lat, ok);
      check($sformatf("rnd%0d read_back", i), rd, model_read(a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
